// File: rtl/csi2_frame_controller_if.sv
// Event input and pixel output signals of the CSI-2 frame controller.
// The master modport drives events; the slave modport is the controller side.
interface csi2_frame_controller_if;
  logic        short_valid;
  logic [5:0]  short_type;
  logic [1:0]  short_vc;
  logic [15:0] short_data;
  logic        word_valid;
  logic [1:0]  word_vc;
  logic [31:0] word_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eol;

  modport master (
    output short_valid, short_type, short_vc, short_data,
    output word_valid, word_vc, word_data,
    output out_ready,
    input  out_valid, out_data, out_sof, out_eol
  );

  modport slave (
    input  short_valid, short_type, short_vc, short_data,
    input  word_valid, word_vc, word_data,
    input  out_ready,
    output out_valid, out_data, out_sof, out_eol
  );
endinterface

// File: rtl/csi2_frame_controller.sv
// Frame capture sequencer behind a CSI-2 packet receiver: frames one virtual channel's
// word stream with sof/eol, counts lines and words, and flags geometry/protocol/overflow errors.
module csi2_frame_controller #(
  parameter int unsigned LINE_BITS = 12,
  parameter int unsigned WORD_BITS = 14
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [1:0]           vc_select,
  input  logic [LINE_BITS-1:0] expected_lines,
  input  logic [WORD_BITS-1:0] expected_words,
  csi2_frame_controller_if.slave bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_number,
  output logic [LINE_BITS-1:0] line_count,
  output logic                 err_geometry,
  output logic                 err_protocol,
  output logic                 err_overflow
);

  typedef enum logic [2:0] {StIdle, StWaitFs, StFrame, StLine, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           vc_q, vc_d;
  logic [LINE_BITS-1:0] exp_lines_q, exp_lines_d;
  logic [WORD_BITS-1:0] exp_words_q, exp_words_d;
  logic [15:0]          frame_number_q, frame_number_d;
  logic [LINE_BITS-1:0] line_count_q, line_count_d;
  logic [WORD_BITS-1:0] word_cnt_q, word_cnt_d;
  logic                 sof_pending_q, sof_pending_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 hold_eol_q, hold_eol_d;
  logic                 hold_sof_q, hold_sof_d;
  logic [31:0]          hold_data_q, hold_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_data_q, out_data_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eol_q, out_eol_d;
  logic                 err_geometry_q, err_geometry_d;
  logic                 err_protocol_q, err_protocol_d;
  logic                 err_overflow_q, err_overflow_d;

  logic word_ev, short_ev, is_fs, is_fe, is_ls, is_le;
  logic out_free, release_hold;

  assign word_ev  = bus.word_valid && (bus.word_vc == vc_q);
  assign short_ev = bus.short_valid && (bus.short_vc == vc_q);
  assign is_fs    = short_ev && (bus.short_type == 6'd0);
  assign is_fe    = short_ev && (bus.short_type == 6'd1);
  assign is_ls    = short_ev && (bus.short_type == 6'd2);
  assign is_le    = short_ev && (bus.short_type == 6'd3);

  always_comb begin
    state_d        = state_q;
    vc_d           = vc_q;
    exp_lines_d    = exp_lines_q;
    exp_words_d    = exp_words_q;
    frame_number_d = frame_number_q;
    line_count_d   = line_count_q;
    word_cnt_d     = word_cnt_q;
    sof_pending_d  = sof_pending_q;
    hold_valid_d   = hold_valid_q;
    hold_eol_d     = hold_eol_q;
    hold_sof_d     = hold_sof_q;
    hold_data_d    = hold_data_q;
    out_free       = !out_valid_q || bus.out_ready;
    out_valid_d    = out_valid_q && !bus.out_ready;
    out_data_d     = out_data_q;
    out_sof_d      = out_sof_q;
    out_eol_d      = out_eol_q;
    err_geometry_d = err_geometry_q;
    err_protocol_d = err_protocol_q;
    err_overflow_d = err_overflow_q;
    release_hold   = 1'b0;

    if (abort) begin
      state_d       = StIdle;
      out_valid_d   = 1'b0;
      hold_valid_d  = 1'b0;
      hold_eol_d    = 1'b0;
      sof_pending_d = 1'b0;
    end else begin
      // A word released by LE/FE while the output was full drains as soon as it frees up.
      if (hold_valid_q && hold_eol_q && out_free) begin
        out_valid_d  = 1'b1;
        out_data_d   = hold_data_q;
        out_sof_d    = hold_sof_q;
        out_eol_d    = 1'b1;
        hold_valid_d = 1'b0;
        hold_eol_d   = 1'b0;
        out_free     = 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (arm) begin
            state_d        = StWaitFs;
            vc_d           = vc_select;
            exp_lines_d    = expected_lines;
            exp_words_d    = expected_words;
            err_geometry_d = 1'b0;
            err_protocol_d = 1'b0;
            err_overflow_d = 1'b0;
            line_count_d   = '0;
          end
        end
        StWaitFs: begin
          if (is_fs) begin
            state_d        = StFrame;
            frame_number_d = bus.short_data;
            sof_pending_d  = 1'b1;
            line_count_d   = '0;
          end
        end
        StFrame, StLine: begin
          // The word is processed before any short packet in the same cycle.
          if (word_ev) begin
            if (state_q == StFrame) err_protocol_d = 1'b1;
            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
            if (hold_valid_d && !out_free) begin
              err_overflow_d = 1'b1;
            end else begin
              if (hold_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = hold_data_d;
                out_sof_d   = hold_sof_d;
                out_eol_d   = hold_eol_d;
                out_free    = 1'b0;
              end
              hold_valid_d  = 1'b1;
              hold_eol_d    = 1'b0;
              hold_data_d   = bus.word_data;
              hold_sof_d    = sof_pending_d;
              sof_pending_d = 1'b0;
            end
          end
          if (is_ls) begin
            if (state_q == StLine) err_protocol_d = 1'b1;
            state_d    = StLine;
            word_cnt_d = '0;
          end
          if (is_le) begin
            if (state_q == StFrame) begin
              err_protocol_d = 1'b1;
            end else begin
              state_d      = StFrame;
              line_count_d = line_count_q + 1'b1;
              release_hold = 1'b1;
              if ((exp_words_q != '0) && (word_cnt_d != exp_words_q)) err_geometry_d = 1'b1;
            end
          end
          if (is_fe) begin
            if (state_q == StLine) err_protocol_d = 1'b1;
            state_d      = StDone;
            release_hold = 1'b1;
          end
          if (is_fs) begin
            err_protocol_d = 1'b1;
            state_d        = StFrame;
            frame_number_d = bus.short_data;
            line_count_d   = '0;
            sof_pending_d  = 1'b1;
          end
          if (release_hold && hold_valid_d && !hold_eol_d) begin
            if (out_free) begin
              out_valid_d  = 1'b1;
              out_data_d   = hold_data_d;
              out_sof_d    = hold_sof_d;
              out_eol_d    = 1'b1;
              hold_valid_d = 1'b0;
            end else begin
              hold_eol_d = 1'b1;
            end
          end
        end
        StDone: begin
          if ((exp_lines_q != '0) && (line_count_q != exp_lines_q)) err_geometry_d = 1'b1;
          state_d = continuous ? StWaitFs : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      vc_q           <= '0;
      exp_lines_q    <= '0;
      exp_words_q    <= '0;
      frame_number_q <= '0;
      line_count_q   <= '0;
      word_cnt_q     <= '0;
      sof_pending_q  <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_eol_q     <= 1'b0;
      hold_sof_q     <= 1'b0;
      hold_data_q    <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_sof_q      <= 1'b0;
      out_eol_q      <= 1'b0;
      err_geometry_q <= 1'b0;
      err_protocol_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      vc_q           <= vc_d;
      exp_lines_q    <= exp_lines_d;
      exp_words_q    <= exp_words_d;
      frame_number_q <= frame_number_d;
      line_count_q   <= line_count_d;
      word_cnt_q     <= word_cnt_d;
      sof_pending_q  <= sof_pending_d;
      hold_valid_q   <= hold_valid_d;
      hold_eol_q     <= hold_eol_d;
      hold_sof_q     <= hold_sof_d;
      hold_data_q    <= hold_data_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sof_q      <= out_sof_d;
      out_eol_q      <= out_eol_d;
      err_geometry_q <= err_geometry_d;
      err_protocol_q <= err_protocol_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eol   = out_eol_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = (state_q == StDone);
  assign frame_number  = frame_number_q;
  assign line_count    = line_count_q;
  assign err_geometry  = err_geometry_q;
  assign err_protocol  = err_protocol_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_csi2_frame_controller.sv
// Scenario bench for csi2_frame_controller: expected output words go into a scoreboard
// queue as stimulus is driven and are popped when the output handshake completes.
module tb_csi2_frame_controller;

  localparam logic [5:0] FS = 6'd0;
  localparam logic [5:0] FE = 6'd1;
  localparam logic [5:0] LS = 6'd2;
  localparam logic [5:0] LE = 6'd3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        arm, continuous, abort;
  logic [1:0]  vc_select;
  logic [11:0] expected_lines;
  logic [13:0] expected_words;
  logic        busy, frame_done;
  logic [15:0] frame_number;
  logic [11:0] line_count;
  logic        err_geometry, err_protocol, err_overflow;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [33:0] exp_q[$];

  csi2_frame_controller_if bus ();

  csi2_frame_controller #(
    .LINE_BITS(12),
    .WORD_BITS(14)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .arm           (arm),
    .continuous    (continuous),
    .abort         (abort),
    .vc_select     (vc_select),
    .expected_lines(expected_lines),
    .expected_words(expected_words),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_number  (frame_number),
    .line_count    (line_count),
    .err_geometry  (err_geometry),
    .err_protocol  (err_protocol),
    .err_overflow  (err_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_short(input logic [5:0] t, input logic [1:0] vc, input logic [15:0] d);
    bus.short_valid = 1'b1;
    bus.short_type  = t;
    bus.short_vc    = vc;
    bus.short_data  = d;
    tick(1);
    bus.short_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] vc, input logic [31:0] d);
    bus.word_valid = 1'b1;
    bus.word_vc    = vc;
    bus.word_data  = d;
    tick(1);
    bus.word_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] vc, input logic [11:0] lines, input logic [13:0] words);
    vc_select      = vc;
    expected_lines = lines;
    expected_words = words;
    arm            = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  // Pops the scoreboard on every accepted output word.
  task automatic monitor();
    logic [33:0] got, e;
    forever begin
      @(negedge clock);
      if (frame_done) done_cnt++;
      if (reset_n && bus.out_valid && bus.out_ready) begin
        got = {bus.out_sof, bus.out_eol, bus.out_data};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_unexpected got={sof,eol,data}=%h required=no word", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL out_word got={sof,eol,data}=%h required=%h", got, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.out_valid, busy, frame_done, err_geometry, err_protocol, err_overflow} !== 6'b0 ||
        frame_number !== 16'd0 || line_count !== 12'd0 || bus.out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got valid=%b busy=%b fn=%h lc=%h required all zero",
               bus.out_valid, busy, frame_number, line_count);
    end
  endtask

  task automatic test_basic_frame();
    int d0;
    bus.out_ready = 1'b1;
    d0 = done_cnt;
    do_arm(2'd0, 12'd2, 14'd3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy got=%b required=1", busy);
    end
    send_short(FS, 2'd0, 16'd7);
    for (int l = 0; l < 2; l++) begin
      send_short(LS, 2'd0, 16'(l));
      for (int w = 0; w < 3; w++) begin
        exp_q.push_back({(l == 0 && w == 0), (w == 2), 32'hA000_0000 + 32'(l * 16 + w)});
        send_word(2'd0, 32'hA000_0000 + 32'(l * 16 + w));
      end
      send_short(LE, 2'd0, 16'(l));
    end
    send_short(FE, 2'd0, 16'd7);
    tick(3);
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL basic_frame_done got=%0d required=1", done_cnt - d0);
    end
    vectors++;
    if (frame_number !== 16'd7 || line_count !== 12'd2) begin
      miscompares++;
      $display("FAIL basic_counts got fn=%0d lc=%0d required fn=7 lc=2", frame_number, line_count);
    end
    vectors++;
    if ({err_geometry, err_protocol, err_overflow, busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL basic_errors got geo=%b prot=%b ovf=%b busy=%b required 0000",
               err_geometry, err_protocol, err_overflow, busy);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_geometry();
    int d0;
    d0 = done_cnt;
    do_arm(2'd0, 12'd2, 14'd3);
    send_short(FS, 2'd0, 16'd8);
    for (int l = 0; l < 2; l++) begin
      send_short(LS, 2'd0, 16'(l));
      for (int w = 0; w < 3 - l; w++) begin
        exp_q.push_back({(l == 0 && w == 0), (w == 2 - l), 32'hB000_0000 + 32'(l * 16 + w)});
        send_word(2'd0, 32'hB000_0000 + 32'(l * 16 + w));
      end
      send_short(LE, 2'd0, 16'(l));
      vectors++;
      if (err_geometry !== (l == 1)) begin
        miscompares++;
        $display("FAIL geometry_line%0d got=%b required=%b", l, err_geometry, (l == 1));
      end
    end
    send_short(FE, 2'd0, 16'd8);
    tick(3);
    vectors++;
    if (done_cnt - d0 !== 1 || err_geometry !== 1'b1) begin
      miscompares++;
      $display("FAIL geometry_done got done=%0d geo=%b required done=1 geo=1",
               done_cnt - d0, err_geometry);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL geometry_drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_vc_filter();
    do_arm(2'd0, 12'd0, 14'd0);
    vectors++;
    if (err_geometry !== 1'b0) begin
      miscompares++;
      $display("FAIL arm_clears_errors got geo=%b required 0", err_geometry);
    end
    send_short(FS, 2'd1, 16'h55);
    send_short(LS, 2'd1, 16'h0);
    send_word(2'd1, 32'hDEAD_0001);
    send_word(2'd1, 32'hDEAD_0002);
    send_short(LE, 2'd1, 16'h0);
    send_word(2'd0, 32'hDEAD_0003);
    tick(3);
    vectors++;
    if (busy !== 1'b1 || frame_number !== 16'd8 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL vc_filter got busy=%b fn=%h valid=%b required busy=1 fn=0008 valid=0",
               busy, frame_number, bus.out_valid);
    end
    do_abort();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL vc_abort_idle got busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    do_arm(2'd0, 12'd0, 14'd0);
    send_short(FS, 2'd0, 16'd3);
    send_short(LS, 2'd0, 16'd0);
    exp_q.push_back({1'b1, 1'b0, 32'hC000_0000});
    exp_q.push_back({1'b0, 1'b1, 32'hC000_0001});
    send_word(2'd0, 32'hC000_0000);
    send_word(2'd0, 32'hC000_0001);
    send_word(2'd0, 32'hC000_0002);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.out_valid, bus.out_sof, bus.out_eol, bus.out_data} !== {3'b110, 32'hC000_0000}) begin
        miscompares++;
        $display("FAIL bp_hold%0d got v=%b s=%b e=%b d=%h required v=1 s=1 e=0 d=c0000000",
                 i, bus.out_valid, bus.out_sof, bus.out_eol, bus.out_data);
      end
      tick(1);
    end
    vectors++;
    if (err_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_overflow got=%b required=1", err_overflow);
    end
    send_short(LE, 2'd0, 16'd0);
    bus.out_ready = 1'b1;
    tick(3);
    send_short(FE, 2'd0, 16'd3);
    tick(3);
    vectors++;
    if (exp_q.size() != 0 || err_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got pending=%0d ovf=%b required pending=0 ovf=1",
               exp_q.size(), err_overflow);
    end
  endtask

  task automatic test_continuous();
    int d0;
    d0 = done_cnt;
    continuous = 1'b1;
    do_arm(2'd0, 12'd1, 14'd2);
    for (int f = 0; f < 2; f++) begin
      send_short(FS, 2'd0, 16'(20 + f));
      send_short(LS, 2'd0, 16'd0);
      exp_q.push_back({1'b1, 1'b0, 32'hD000_0000 + 32'(f * 2)});
      exp_q.push_back({1'b0, 1'b1, 32'hD000_0001 + 32'(f * 2)});
      send_word(2'd0, 32'hD000_0000 + 32'(f * 2));
      send_word(2'd0, 32'hD000_0001 + 32'(f * 2));
      send_short(LE, 2'd0, 16'd0);
      send_short(FE, 2'd0, 16'(20 + f));
      tick(1);
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL cont_busy%0d got=%b required=1", f, busy);
      end
    end
    tick(2);
    vectors++;
    if (done_cnt - d0 !== 2 || frame_number !== 16'd21) begin
      miscompares++;
      $display("FAIL cont_frames got done=%0d fn=%0d required done=2 fn=21",
               done_cnt - d0, frame_number);
    end
    vectors++;
    if (exp_q.size() != 0 || {err_geometry, err_protocol, err_overflow} !== 3'b0) begin
      miscompares++;
      $display("FAIL cont_clean got pending=%0d errs=%b%b%b required 0 000",
               exp_q.size(), err_geometry, err_protocol, err_overflow);
    end
    continuous = 1'b0;
    do_abort();
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    do_arm(2'd0, 12'd0, 14'd0);
    send_short(FS, 2'd0, 16'd4);
    send_short(LS, 2'd0, 16'd0);
    send_word(2'd0, 32'hE000_0000);
    send_word(2'd0, 32'hE000_0001);
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre_valid got=%b required=1", bus.out_valid);
    end
    do_abort();
    vectors++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle got busy=%b valid=%b required 0 0", busy, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick(2);
    // Only the new frame's word may appear: the aborted holding word must be gone.
    do_arm(2'd0, 12'd0, 14'd0);
    send_short(FS, 2'd0, 16'd9);
    send_short(LS, 2'd0, 16'd0);
    exp_q.push_back({1'b1, 1'b1, 32'hE000_0009});
    send_word(2'd0, 32'hE000_0009);
    send_short(LE, 2'd0, 16'd0);
    send_short(FE, 2'd0, 16'd9);
    tick(3);
    vectors++;
    if (done_cnt - d0 !== 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_after got done=%0d pending=%0d required done=1 pending=0",
               done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_protocol();
    do_arm(2'd0, 12'd0, 14'd0);
    send_short(FS, 2'd0, 16'd11);
    send_short(LE, 2'd0, 16'd0);
    vectors++;
    if (err_protocol !== 1'b1) begin
      miscompares++;
      $display("FAIL protocol_le_in_frame got=%b required=1", err_protocol);
    end
    send_short(FE, 2'd0, 16'd11);
    tick(3);
    vectors++;
    if (err_geometry !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL protocol_end got geo=%b busy=%b required 0 0", err_geometry, busy);
    end
  endtask

  task automatic test_reset_midline();
    bus.out_ready = 1'b0;
    do_arm(2'd0, 12'd0, 14'd0);
    send_short(FS, 2'd0, 16'd5);
    send_short(LS, 2'd0, 16'd0);
    send_word(2'd0, 32'hF000_0000);
    send_word(2'd0, 32'hF000_0001);
    send_word(2'd0, 32'hF000_0002);
    reset_n = 1'b0;
    @(negedge clock);
    test_reset();
    tick(1);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    tick(3);
    test_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_pending got=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    arm             = 1'b0;
    continuous      = 1'b0;
    abort           = 1'b0;
    vc_select       = 2'd0;
    expected_lines  = '0;
    expected_words  = '0;
    bus.short_valid = 1'b0;
    bus.short_type  = '0;
    bus.short_vc    = '0;
    bus.short_data  = '0;
    bus.word_valid  = 1'b0;
    bus.word_vc     = '0;
    bus.word_data   = '0;
    bus.out_ready   = 1'b1;
    fork
      monitor();
    join_none
    tick(2);
    test_reset();
    reset_n = 1'b1;
    tick(1);
    test_basic_frame();
    test_geometry();
    test_vc_filter();
    test_backpressure();
    test_continuous();
    test_abort();
    test_protocol();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
